// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_pipe
// Purpose  : Parametrised 3-stage pipelined floating-point multiplier.
//            Round-to-nearest-even, DAZ on inputs, FTZ on outputs, canonical
//            qNaN, exception flags. Valid/ready stream with a global stall.
// Ports    : clk, rst_n           - clock / async active-low reset
//            in_valid, in_ready   - operand handshake
//            a, b                 - operands {sign, exp, frac}
//            out_valid, out_ready - result handshake
//            z                    - product
//            flags                - {invalid, overflow, underflow, inexact}
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [XW-1:0]    BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);

  // Single stall signal: every stage moves or none does.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, multiply ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]    prod_c;
  logic signed [XW-1:0] exp_c;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  // Subnormal inputs (exp = 0) are flushed to zero.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  assign prod_c = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
  assign exp_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

  logic                 v1, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [PW-1:0]        s1_prod;
  logic signed [XW-1:0] s1_exp;

  // ---------------- S2: normalise ----------------
  // Both mantissas are in [1,2), so the product is in [1,4): at most one
  // right shift is ever needed.
  logic                 msb;
  logic [MAN_W-1:0]     kept_c;
  logic                 guard_c, sticky_c;
  logic signed [XW-1:0] exp2_c;

  assign msb      = s1_prod[PW-1];
  assign kept_c   = msb ? s1_prod[PW-2:MAN_W+1] : s1_prod[PW-3:MAN_W];
  assign guard_c  = msb ? s1_prod[MAN_W]        : s1_prod[MAN_W-1];
  assign sticky_c = msb ? (|s1_prod[MAN_W-1:0]) : (|s1_prod[MAN_W-2:0]);
  assign exp2_c   = s1_exp + $signed({{(XW-1){1'b0}}, msb});

  logic                 v2, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [MAN_W-1:0]     s2_kept;
  logic                 s2_guard, s2_sticky;
  logic signed [XW-1:0] s2_exp;

  // ---------------- S3: round and pack ----------------
  logic                 inc;
  logic [MAN_W:0]       rnd;
  logic signed [XW-1:0] exp_f;
  logic [W-1:0]         z_c;
  logic [3:0]           flags_c;

  assign inc   = s2_guard & (s2_sticky | s2_kept[0]);
  // A carry out of the mantissa leaves the low bits all zero, which is
  // exactly the renormalised fraction.
  assign rnd   = {1'b0, s2_kept} + {{MAN_W{1'b0}}, inc};
  assign exp_f = s2_exp + $signed({{(XW-1){1'b0}}, rnd[MAN_W]});

  always_comb begin
    z_c     = '0;
    flags_c = 4'b0000;
    if (s2_nan) begin
      z_c     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_c = 4'b1000;
    end else if (s2_inf) begin
      z_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      z_c = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      z_c     = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end else if (exp_f[XW-1] || (exp_f == '0)) begin
      z_c     = {s2_sign, {(W-1){1'b0}}};
      flags_c = 4'b0011;
    end else begin
      z_c     = {s2_sign, exp_f[EXP_W-1:0], rnd[MAN_W-1:0]};
      flags_c = {3'b000, s2_guard | s2_sticky};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_prod   <= '0;
      s1_exp    <= '0;
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_kept   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_exp    <= '0;
      out_valid <= 1'b0;
      z         <= '0;
      flags     <= 4'b0000;
    end else if (adv) begin
      v1        <= in_valid;
      s1_sign   <= sa ^ sb;
      s1_nan    <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      s1_inf    <= a_inf | b_inf;
      s1_zero   <= a_zero | b_zero;
      s1_prod   <= prod_c;
      s1_exp    <= exp_c;
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_kept   <= kept_c;
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
      s2_exp    <= exp2_c;
      out_valid <= v2;
      // Result registers only change when a real result lands.
      if (v2) begin
        z     <= z_c;
        flags <= flags_c;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_pipe
// Purpose  : Self-checking bench for fp_mul_pipe (binary16 and bfloat16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // binary16 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, z;
  logic [3:0]  flags;
  // bfloat16 instance
  logic        bf_in_valid, bf_in_ready, bf_out_valid, bf_out_ready;
  logic [15:0] bf_a, bf_b, bf_z;
  logic [3:0]  bf_flags;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .BIAS(127)) dut_bf (
    .clk(clk), .rst_n(rst_n), .in_valid(bf_in_valid), .in_ready(bf_in_ready),
    .a(bf_a), .b(bf_b), .out_valid(bf_out_valid), .out_ready(bf_out_ready),
    .z(bf_z), .flags(bf_flags)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Golden model: exact real-valued product, then round-to-nearest-even of
  // the significand; specials and FTZ/DAZ decided from the decoded fields.
  function automatic void model(input int ew, input int mw, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] zv,
                                output logic [3:0] fv);
    int  ones, bias, ua, ub, sa, sb, ea, eb, fa, fb, s, e, be, q;
    bit  za, zb, ia, ib, na, nb;
    real scale, v, x, fl, rem;
    ones = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ua = int'(av); ub = int'(bv);
    sa = (ua >> (ew + mw)) & 1;  sb = (ub >> (ew + mw)) & 1;
    ea = (ua >> mw) & ones;      eb = (ub >> mw) & ones;
    fa = ua & ((1 << mw) - 1);   fb = ub & ((1 << mw) - 1);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == ones) && (fa == 0); ib = (eb == ones) && (fb == 0);
    na = (ea == ones) && (fa != 0); nb = (eb == ones) && (fb != 0);
    s = sa ^ sb;
    if (na || nb || (ia && zb) || (za && ib)) begin
      zv = 32'((ones << mw) | (1 << (mw - 1))); fv = 4'b1000;
    end else if (ia || ib) begin
      zv = 32'((s << (ew + mw)) | (ones << mw)); fv = 4'b0000;
    end else if (za || zb) begin
      zv = 32'(s << (ew + mw)); fv = 4'b0000;
    end else begin
      scale = real'(1 << mw);
      v = (1.0 + real'(fa) / scale) * (1.0 + real'(fb) / scale);
      e = ea + eb - 2 * bias;
      if (v >= 2.0) begin v = v / 2.0; e++; end
      x   = v * scale;
      fl  = $floor(x);
      rem = x - fl;
      q   = int'(fl);
      if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
      if (q == (2 << mw)) begin q = 1 << mw; e++; end
      be = e + bias;
      if (be >= ones) begin
        zv = 32'((s << (ew + mw)) | (ones << mw)); fv = 4'b0101;
      end else if (be <= 0) begin
        zv = 32'(s << (ew + mw)); fv = 4'b0011;
      end else begin
        zv = 32'((s << (ew + mw)) | (be << mw) | (q - (1 << mw)));
        fv = (rem != 0.0) ? 4'b0001 : 4'b0000;
      end
    end
  endfunction

  // ---------------- scoreboard and per-cycle compare ----------------
  logic [15:0] exp_z_q[$];
  logic [3:0]  exp_f_q[$];
  bit          prev_stall = 1'b0;
  logic [15:0] prev_z;
  logic [3:0]  prev_f;

  always @(negedge clk) begin
    logic [31:0] mz;
    logic [3:0]  mf;
    if (rst_n) begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready_rule", {31'd0, in_ready},
          {31'd0, !(out_valid && !out_ready)});
      if (prev_stall)
        chk(z == prev_z && flags == prev_f, "hold_stable", {12'd0, flags, z}, {12'd0, prev_f, prev_z});
      if (out_valid && out_ready) begin
        if (exp_z_q.size() == 0) begin
          chk(1'b0, "spurious_output", {16'd0, z}, 32'd0);
        end else begin
          mz = {16'd0, exp_z_q.pop_front()};
          mf = exp_f_q.pop_front();
          chk(z == mz[15:0], "z_vs_model", {16'd0, z}, mz);
          chk(flags == mf, "flags_vs_model", {28'd0, flags}, {28'd0, mf});
        end
      end
      if (in_valid && in_ready) begin
        model(5, 10, {16'd0, a}, {16'd0, b}, mz, mf);
        exp_z_q.push_back(mz[15:0]);
        exp_f_q.push_back(mf);
      end
      prev_stall = out_valid && !out_ready;
      prev_z = z;
      prev_f = flags;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed vectors (binary16) ----------------
  localparam int ND = 8;
  logic [15:0] d_a[ND] = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h7C00, 16'hFC00, 16'h7BFF, 16'h0400, 16'h0001};
  logic [15:0] d_b[ND] = '{16'h3E00, 16'h3E00, 16'h3C01, 16'h0000, 16'h4000, 16'h4000, 16'h3800, 16'h3C00};
  logic [15:0] d_z[ND] = '{16'h4080, 16'h3E02, 16'h3C02, 16'h7E00, 16'hFC00, 16'h7C00, 16'h0000, 16'h0000};
  logic [3:0]  d_f[ND] = '{4'h0,     4'h1,     4'h1,     4'h8,     4'h0,     4'h5,     4'h3,     4'h0};

  task automatic drain(input string name);
    int cyc = 0;
    out_ready = 1'b1;
    while (exp_z_q.size() != 0 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    chk(exp_z_q.size() == 0, name, exp_z_q.size(), 32'd0);
  endtask

  task automatic bf_run(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ez, input logic [3:0] ef, input string name);
    int cyc = 0;
    logic [31:0] mz;
    logic [3:0]  mf;
    model(8, 7, {16'd0, x}, {16'd0, y}, mz, mf);
    chk(mz[15:0] == ez && mf == ef, {name, "_model_pin"}, {12'd0, mf, mz[15:0]}, {12'd0, ef, ez});
    @(posedge clk); #1;
    bf_in_valid = 1'b1; bf_a = x; bf_b = y;
    @(posedge clk); #1;
    bf_in_valid = 1'b0;
    while (!bf_out_valid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk(bf_out_valid == 1'b1, {name, "_timeout"}, {31'd0, bf_out_valid}, 32'd1);
    chk(bf_z == ez && bf_flags == ef, name, {12'd0, bf_flags, bf_z}, {12'd0, ef, ez});
  endtask

  initial begin
    logic [31:0] mz;
    logic [3:0]  mf;
    logic [15:0] va[8], vb[8];
    int cyc, idx;
    bit acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    bf_in_valid = 1'b0; bf_out_ready = 1'b1; bf_a = '0; bf_b = '0;
    #1;
    chk(out_valid == 1'b0 && z == 16'h0 && flags == 4'h0, "reset_state",
        {11'd0, out_valid, flags, z}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model against hand-computed results.
    for (int i = 0; i < ND; i++) begin
      model(5, 10, {16'd0, d_a[i]}, {16'd0, d_b[i]}, mz, mf);
      chk(mz[15:0] == d_z[i] && mf == d_f[i], "model_pin", {12'd0, mf, mz[15:0]}, {12'd0, d_f[i], d_z[i]});
    end

    // Latency: issue one operand pair, count cycles until out_valid.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h3E00; b = 16'h3E00;
    cyc = 0;
    while (cyc < 10) begin
      @(posedge clk); #1; cyc++;
      in_valid = 1'b0;
      if (out_valid) break;
    end
    chk(cyc == 3 && out_valid, "latency", cyc, 32'd3);
    chk(z == 16'h4080 && flags == 4'h0, "first_result", {12'd0, flags, z}, 32'h0000_4080);
    drain("drain_latency");

    // Directed vectors, back-to-back, each also checked literally on exit.
    for (int i = 0; i < ND; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = d_a[i]; b = d_b[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Last vector sits in S1 now; it reaches the output two edges later.
    repeat (2) @(posedge clk);
    #1;
    chk(out_valid && z == d_z[ND-1] && flags == d_f[ND-1], "last_directed",
        {11'd0, out_valid, flags, z}, {11'd0, 1'b1, d_f[ND-1], d_z[ND-1]});
    drain("drain_directed");

    // Random normal stream with out_ready toggling.
    for (int i = 0; i < 8; i++) begin
      va[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom)};
      vb[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom)};
    end
    va[7] = 16'h0401; vb[7] = 16'h3A00;   // lands near the underflow edge
    @(posedge clk); #1;
    idx = 0;
    in_valid = 1'b1; a = va[0]; b = vb[0]; out_ready = 1'($urandom_range(0, 1));
    for (cyc = 0; cyc < 300 && idx < 8; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 8) begin a = va[idx]; b = vb[idx]; end
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
    end
    chk(idx == 8, "stream_accept", idx, 32'd8);
    in_valid = 1'b0;
    drain("drain_stream");

    // Reset with three results in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = d_a[i]; b = d_b[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0 && z == 16'h0 && flags == 4'h0, "async_reset",
        {11'd0, out_valid, flags, z}, 32'd0);
    exp_z_q.delete();
    exp_f_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    acc = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) acc = 1'b1;
    end
    chk(acc == 1'b0, "no_output_after_reset", {31'd0, acc}, 32'd0);

    // bfloat16 parameterisation.
    bf_run(16'h3FC0, 16'h3FC0, 16'h4010, 4'h0, "bf16_mul");
    bf_run(16'h7F80, 16'h0000, 16'h7FC0, 4'h8, "bf16_inf_x_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
